// File: rtl/vscale_dmem_responder_pkg.sv
// Shared constants and types for the vscale dmem responder and its helpers.
// Size codes and widths follow the core's platform constants.
package vscale_dmem_responder_pkg;

   localparam int unsigned XPR_LEN        = 32;
   localparam int unsigned MEM_TYPE_WIDTH = 3;
   localparam int unsigned WAIT_CNT_W     = 4;

   localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_B = 3'd0;
   localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_H = 3'd1;
   localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_W = 3'd2;

   typedef enum logic [1:0] {
      DMEM_IDLE,
      DMEM_WAIT,
      DMEM_DATA
   } dmem_state_e;

endpackage

// File: rtl/vscale_dmem_responder_if.sv
// dmem port bundle between the vscale pipeline (master) and a data memory (slave).
interface vscale_dmem_responder_if;
   import vscale_dmem_responder_pkg::*;

   logic                      dmem_en;
   logic                      dmem_wen;
   logic [MEM_TYPE_WIDTH-1:0] dmem_size;
   logic [XPR_LEN-1:0]        dmem_addr;
   logic [XPR_LEN-1:0]        dmem_wdata_delayed;
   logic [XPR_LEN-1:0]        dmem_rdata;
   logic                      dmem_wait;
   logic                      dmem_badmem_e;

   modport master (
      output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
      input  dmem_rdata, dmem_wait, dmem_badmem_e
   );

   modport slave (
      input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
      output dmem_rdata, dmem_wait, dmem_badmem_e
   );

endinterface

// File: rtl/vscale_dmem_bytemask.sv
// Byte-lane enables for a sized access within a 32-bit word, plus a flag for
// illegal size codes and misaligned half/word accesses.
module vscale_dmem_bytemask
   import vscale_dmem_responder_pkg::*;
(
   input  logic [MEM_TYPE_WIDTH-1:0] size_i,
   input  logic [1:0]                addr_lo_i,
   output logic [3:0]                mask_o,
   output logic                      illegal_o
);

   always_comb begin
      mask_o    = '0;
      illegal_o = 1'b0;
      case (size_i)
         MEM_TYPE_B: mask_o = 4'b0001 << addr_lo_i;
         MEM_TYPE_H: begin
            mask_o    = 4'b0011 << addr_lo_i;
            illegal_o = addr_lo_i[0];
         end
         MEM_TYPE_W: begin
            mask_o    = 4'b1111;
            illegal_o = |addr_lo_i;
         end
         default: illegal_o = 1'b1;
      endcase
      if (illegal_o) begin
         mask_o = '0;
      end
   end

endmodule

// File: rtl/vscale_dmem_responder.sv
// Data-memory slave for the vscale dmem port: accepts in DX, completes in the
// data phase after WAIT_CYCLES wait states, reports faults, owns the word RAM.
module vscale_dmem_responder
   import vscale_dmem_responder_pkg::*;
#(
   parameter int unsigned        DEPTH_WORDS = 4096,
   parameter logic [XPR_LEN-1:0] BASE_ADDR   = '0,
   parameter int unsigned        WAIT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   vscale_dmem_responder_if.slave dmem
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   dmem_state_e           state_q;
   logic [WAIT_CNT_W-1:0] cnt_q;
   logic                  wen_q;
   logic                  err_q;
   logic [3:0]            be_q;
   logic [IDX_W-1:0]      word_q;

   logic [XPR_LEN-1:0]    offset_d;
   logic [IDX_W-1:0]      word_d;
   logic                  in_range_d;
   logic                  illegal_d;
   logic                  err_d;
   logic [3:0]            be_d;
   logic                  data_phase_d;
   logic                  commit_d;

   logic [XPR_LEN-1:0]    mem [DEPTH_WORDS];

   // BASE_ADDR is window-aligned, so the offset's low bits equal addr[1:0].
   assign offset_d   = dmem.dmem_addr - BASE_ADDR;
   assign word_d     = offset_d[IDX_W+1:2];
   assign in_range_d = (offset_d[XPR_LEN-1:IDX_W+2] == '0);
   assign err_d      = illegal_d | ~in_range_d;

   vscale_dmem_bytemask u_bytemask (
      .size_i    (dmem.dmem_size),
      .addr_lo_i (offset_d[1:0]),
      .mask_o    (be_d),
      .illegal_o (illegal_d)
   );

   // The lane mask is latched in place of size/addr[1:0]; it is all the data phase needs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DMEM_IDLE;
         cnt_q   <= '0;
         wen_q   <= 1'b0;
         err_q   <= 1'b0;
         be_q    <= '0;
         word_q  <= '0;
      end else begin
         case (state_q)
            DMEM_WAIT: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == WAIT_CNT_W'(1)) begin
                  state_q <= DMEM_DATA;
               end
            end
            default: begin
               if (dmem.dmem_en) begin
                  wen_q   <= dmem.dmem_wen;
                  err_q   <= err_d;
                  be_q    <= be_d;
                  word_q  <= word_d;
                  cnt_q   <= WAIT_CNT_W'(WAIT_CYCLES);
                  state_q <= (WAIT_CYCLES == 0) ? DMEM_DATA : DMEM_WAIT;
               end else begin
                  state_q <= DMEM_IDLE;
               end
            end
         endcase
      end
   end

   assign data_phase_d = (state_q == DMEM_DATA);
   assign commit_d     = ~reset & data_phase_d & wen_q & ~err_q;

   always_ff @(posedge clk) begin
      if (commit_d) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be_q[b]) begin
               mem[word_q][8*b +: 8] <= dmem.dmem_wdata_delayed[8*b +: 8];
            end
         end
      end
   end

   assign dmem.dmem_wait     = (state_q == DMEM_WAIT);
   assign dmem.dmem_badmem_e = data_phase_d & err_q;
   assign dmem.dmem_rdata    = (data_phase_d && !wen_q && !err_q) ? mem[word_q] : '0;

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Bench for vscale_dmem_responder: three instances (0, 2 and 3 wait states)
// checked against a byte-array transaction model, directed tables and random traffic.
module tb_vscale_dmem_responder;

   localparam int unsigned DEPTH   = 256;
   localparam int unsigned WIN     = 4 * DEPTH;
   localparam logic [31:0] BASE_HI = 32'h0000_1000;

   typedef struct {
      bit          wen;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      logic [31:0] rdata;
      logic        bad;
      int          cyc;
   } res_t;

   typedef struct {
      int          d;
      req_t        r;
      logic        bad;
      logic [31:0] rd;
   } vec_t;

   logic        clk = 1'b0;
   logic [2:0]  rst;
   int          sel;
   logic        en;
   logic        wen;
   logic [2:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata_v [3];
   logic [2:0]  wait_v;
   logic [2:0]  bad_v;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      vscale_dmem_responder_if bus ();
      assign bus.dmem_en            = en && (sel == g);
      assign bus.dmem_wen           = wen;
      assign bus.dmem_size          = size;
      assign bus.dmem_addr          = addr;
      assign bus.dmem_wdata_delayed = wdata;
      assign rdata_v[g]             = bus.dmem_rdata;
      assign wait_v[g]              = bus.dmem_wait;
      assign bad_v[g]               = bus.dmem_badmem_e;

      vscale_dmem_responder #(
         .DEPTH_WORDS (DEPTH),
         .BASE_ADDR   ((g == 0) ? 32'h0 : BASE_HI),
         .WAIT_CYCLES ((g == 0) ? 0 : (g == 1) ? 2 : 3)
      ) u_dut (
         .clk   (clk),
         .reset (rst[g]),
         .dmem  (bus)
      );
   end

   logic [7:0] refmem [3][WIN];
   req_t       reqq[$];
   res_t       resq[$];
   vec_t       vecs[$];
   req_t       pend;
   bit         pend_v;
   bit         pend_err;
   int         left;
   int         cyc;
   int         checks;
   int         errors;

   function automatic logic [31:0] base_of(input int d);
      return (d == 0) ? 32'h0 : BASE_HI;
   endfunction

   function automatic int waits_of(input int d);
      return (d == 0) ? 0 : (d == 1) ? 2 : 3;
   endfunction

   function automatic bit ref_err(input int d, input req_t r);
      if (r.size > 3'd2) return 1'b1;
      if (r.size == 3'd1 && r.addr[0]) return 1'b1;
      if (r.size == 3'd2 && r.addr[1:0] != 2'b00) return 1'b1;
      return (r.addr < base_of(d)) || (r.addr >= base_of(d) + WIN);
   endfunction

   function automatic logic [31:0] ref_word(input int d, input logic [31:0] a);
      int unsigned b;
      b = (a - base_of(d)) & ~32'd3;
      return {refmem[d][b+3], refmem[d][b+2], refmem[d][b+1], refmem[d][b]};
   endfunction

   // Each stored byte comes from the lane its own address selects.
   task automatic ref_write(input int d, input req_t r);
      int unsigned off;
      int unsigned lane;
      off = r.addr - base_of(d);
      for (int unsigned i = 0; i < (32'd1 << r.size); i++) begin
         lane = (r.addr + i) & 32'd3;
         refmem[d][off+i] = r.wdata[8*lane +: 8];
      end
   endtask

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
      end
   endtask

   function automatic req_t rand_req(input int d);
      req_t        r;
      int unsigned k;
      int unsigned off;
      k       = $urandom_range(99);
      r.wen   = 1'($urandom_range(1));
      r.size  = (k < 5) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2));
      r.wdata = $urandom;
      off     = $urandom_range(WIN - 1);
      if (k >= 5 && k < 80) off = off & ~((32'd1 << r.size) - 32'd1);
      r.addr = base_of(d) + off;
      if (k >= 90 && k < 95) r.addr = base_of(d) + WIN + $urandom_range(255);
      if (k >= 95) r.addr = base_of(d) - $urandom_range(64, 1);
      return r;
   endfunction

   task automatic row(input int d, input bit w, input logic [2:0] s, input logic [31:0] a,
                      input logic [31:0] wd, input logic bad, input logic [31:0] rd);
      vec_t v;
      v.d = d; v.r.wen = w; v.r.size = s; v.r.addr = a; v.r.wdata = wd;
      v.bad = bad; v.rd = rd;
      vecs.push_back(v);
   endtask

   // Entered and left at posedge+1; issues queued requests whenever the model says the port is free.
   task automatic run_queue(input int d, input int budget, input int unsigned idle_pct);
      int          n;
      bit          free;
      bit          offer;
      logic [31:0] exp_rd;
      n = 0;
      while ((reqq.size() != 0 || pend_v) && n < budget) begin
         free  = !pend_v || (left == 0);
         offer = free && (reqq.size() != 0) && ($urandom_range(99) >= idle_pct);
         sel   = d;
         if (offer) begin
            en = 1'b1; wen = reqq[0].wen; size = reqq[0].size; addr = reqq[0].addr;
         end else if (!free) begin
            en = 1'($urandom_range(1)); wen = 1'($urandom_range(1));
            size = 3'($urandom_range(7)); addr = $urandom;
         end else begin
            en = 1'b0;
         end
         wdata = (pend_v && left == 0 && pend.wen) ? pend.wdata : $urandom;
         @(negedge clk);
         exp_rd = (pend_v && left == 0 && !pend_err && !pend.wen) ? ref_word(d, pend.addr) : '0;
         chk("wait", d, 32'(wait_v[d]), 32'(pend_v && left != 0));
         chk("badmem", d, 32'(bad_v[d]), 32'(pend_v && left == 0 && pend_err));
         chk("rdata", d, rdata_v[d], exp_rd);
         if (pend_v && left == 0) resq.push_back('{rdata_v[d], bad_v[d], cyc});
         @(posedge clk);
         if (pend_v && left == 0) begin
            if (pend.wen && !pend_err) ref_write(d, pend);
            pend_v = 1'b0;
         end else if (pend_v) begin
            left--;
         end
         if (offer) begin
            pend     = reqq.pop_front();
            pend_v   = 1'b1;
            pend_err = ref_err(d, pend);
            left     = waits_of(d);
         end
         #1;
         cyc++;
         n++;
      end
      en = 1'b0;
      if (reqq.size() != 0 || pend_v) begin
         checks++;
         errors++;
         $display("FAIL timeout dut%0d: %0d requests left after %0d cycles, expected 0", d, reqq.size(), n);
         reqq.delete();
         pend_v = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at t=%0t, expected to have finished", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int          idx[$];
      logic [31:0] old;
      req_t        r;

      checks = 0; errors = 0; cyc = 0; pend_v = 1'b0; left = 0;
      en = 1'b0; wen = 1'b0; size = '0; addr = '0; wdata = '0; sel = 0;
      rst = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("rst_wait", d, 32'(wait_v[d]), 32'd0);
         chk("rst_badmem", d, 32'(bad_v[d]), 32'd0);
         chk("rst_rdata", d, rdata_v[d], 32'd0);
      end
      @(posedge clk);
      #1;
      rst = '0;

      for (int d = 0; d < 3; d++) begin
         for (int unsigned w = 0; w < DEPTH; w++) begin
            r.wen = 1'b1; r.size = 3'd2; r.addr = base_of(d) + 4*w; r.wdata = $urandom;
            reqq.push_back(r);
         end
         run_queue(d, 1200, 0);
      end

      row(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 32'h0);
      row(0, 0, 3'd2, 32'h100, 32'h0,        0, 32'hDEADBEEF);
      row(0, 1, 3'd2, 32'h200, 32'h11223344, 0, 32'h0);
      row(0, 1, 3'd0, 32'h203, 32'hAAAAAAAA, 0, 32'h0);
      row(0, 0, 3'd2, 32'h200, 32'h0,        0, 32'hAA223344);
      row(0, 1, 3'd1, 32'h102, 32'h55AA55AA, 0, 32'h0);
      row(0, 0, 3'd1, 32'h101, 32'h0,        1, 32'h0);
      row(0, 1, 3'd1, 32'h101, 32'hFFFFFFFF, 1, 32'h0);
      row(0, 0, 3'd2, 32'h100, 32'h0,        0, 32'h55AABEEF);
      row(0, 1, 3'd2, 32'h3FC, 32'hCAFEF00D, 0, 32'h0);
      row(0, 0, 3'd2, 32'h400, 32'h0,        1, 32'h0);
      row(0, 0, 3'd2, 32'h3FC, 32'h0,        0, 32'hCAFEF00D);
      row(0, 0, 3'd3, 32'h100, 32'h0,        1, 32'h0);
      row(0, 1, 3'd0, 32'h101, 32'h12121212, 0, 32'h0);
      row(0, 0, 3'd0, 32'h102, 32'h0,        0, 32'h55AA12EF);
      row(0, 1, 3'd2, 32'h102, 32'h99999999, 1, 32'h0);
      row(0, 0, 3'd2, 32'h100, 32'h0,        0, 32'h55AA12EF);
      row(1, 1, 3'd2, 32'h1010, 32'h0BADF00D, 0, 32'h0);
      row(1, 0, 3'd2, 32'h1010, 32'h0,        0, 32'h0BADF00D);
      row(1, 0, 3'd2, 32'h0FFC, 32'h0,        1, 32'h0);
      row(1, 0, 3'd1, 32'h1012, 32'h0,        0, 32'h0BADF00D);
      row(1, 1, 3'd1, 32'h1400, 32'h77777777, 1, 32'h0);
      row(1, 0, 3'd2, 32'h1010, 32'h0,        0, 32'h0BADF00D);

      for (int d = 0; d < 2; d++) begin
         idx.delete();
         resq.delete();
         foreach (vecs[i]) begin
            if (vecs[i].d == d) begin
               reqq.push_back(vecs[i].r);
               idx.push_back(i);
            end
         end
         run_queue(d, 200, 0);
         chk("tbl_count", d, resq.size(), idx.size());
         for (int j = 0; j < idx.size() && j < resq.size(); j++) begin
            chk("tbl_badmem", d, 32'(resq[j].bad), 32'(vecs[idx[j]].bad));
            chk("tbl_rdata", d, resq[j].rdata, vecs[idx[j]].rd);
            if (j > 0) chk("tbl_spacing", d, resq[j].cyc - resq[j-1].cyc, waits_of(d) + 1);
         end
      end

      // Reset lands in the second wait cycle of a store; the store must be dropped.
      old = ref_word(2, BASE_HI + 32'h40);
      sel = 2; en = 1'b1; wen = 1'b1; size = 3'd2; addr = BASE_HI + 32'h40; wdata = 32'h55;
      @(negedge clk); chk("rs_idle_wait", 2, 32'(wait_v[2]), 32'd0);
      @(posedge clk); #1;
      @(negedge clk); chk("rs_wait1", 2, 32'(wait_v[2]), 32'd1);
      @(posedge clk); #1;
      rst[2] = 1'b1;
      @(negedge clk); chk("rs_wait2", 2, 32'(wait_v[2]), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rs_wait_after", 2, 32'(wait_v[2]), 32'd0);
      chk("rs_badmem_after", 2, 32'(bad_v[2]), 32'd0);
      chk("rs_rdata_after", 2, rdata_v[2], 32'd0);
      @(posedge clk); #1;
      rst[2] = 1'b0; en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rs_no_accept", 2, 32'(wait_v[2]), 32'd0);
         chk("rs_no_data", 2, 32'(bad_v[2] | (rdata_v[2] != 32'd0)), 32'd0);
         @(posedge clk); #1;
      end
      resq.delete();
      r.wen = 1'b0; r.size = 3'd2; r.addr = BASE_HI + 32'h40; r.wdata = '0;
      reqq.push_back(r);
      run_queue(2, 50, 0);
      chk("rs_count", 2, resq.size(), 1);
      if (resq.size() != 0) chk("rs_old_value", 2, resq[0].rdata, old);

      for (int d = 0; d < 3; d++) begin
         for (int k = 0; k < 150; k++) reqq.push_back(rand_req(d));
         run_queue(d, 2000, 20);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vscale_dmem_responder.md
# vscale_dmem_responder

Data-memory slave for the vscale core's dmem port. It accepts requests issued in the core's DX stage and completes them in the WB-side data phase: read data is returned, or the write data that arrives one phase late is committed. It inserts a programmable number of wait states and flags bad accesses. It sits between the pipeline's dmem outputs and an on-chip word-addressed RAM, and serves as the default test-harness and FPGA data memory.

## Interface
- `DEPTH_WORDS`, default 4096: number of 32-bit words; must be a power of two.
- `BASE_ADDR`, default 32'h0: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `WAIT_CYCLES`, default 0: wait states inserted per access (0–15).

Ports (clock and reset first):
- `clk` in, 1: clock.
- `reset` in, 1: reset, synchronous, active-high.
- `dmem_en` in, 1: request valid.
- `dmem_wen` in, 1: 1 = store, 0 = load.
- `dmem_size` in, `MEM_TYPE_WIDTH`: 0 = byte, 1 = half, 2 = word; other codes are illegal.
- `dmem_addr` in, `XPR_LEN`: byte address.
- `dmem_wdata_delayed` in, `XPR_LEN`: store data, valid in the data phase, already lane-replicated by the core.
- `dmem_rdata` out, `XPR_LEN`: load data (full word; the core extracts the lane).
- `dmem_wait` out, 1: data phase not complete; the core stalls.
- `dmem_badmem_e` out, 1: access fault, valid in the completing data-phase cycle.

## Operation
- **Acceptance.** A request is accepted on any rising edge where `dmem_en=1` and `dmem_wait=0`. On acceptance the block latches `wen`, `size`, `addr[1:0]`, the word index `(addr-BASE_ADDR)>>2`, and the error flag.
- **Error flag.** Set on any of the following:
  - size code ≥ 3;
  - half access with `addr[0]=1`;
  - word access with `addr[1:0]≠0`;
  - address outside `[BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)`.
- **States.**
  - IDLE: no pending access.
  - WAIT: pending access, counter > 0.
  - DATA: pending access, counter = 0.
- **Transitions.**
  - Acceptance loads the counter with `WAIT_CYCLES` and moves to WAIT (if `WAIT_CYCLES>0`) or DATA.
  - WAIT decrements the counter each cycle and moves to DATA when it reaches 1.
  - DATA completes the access. It then goes to IDLE, or straight to WAIT/DATA if a new request is accepted in the same cycle (back-to-back).
- **Outputs.**
  - `dmem_wait = (state==WAIT)`, driven combinationally from the state register.
  - `dmem_rdata = mem[word_q]` combinationally in DATA for a non-error load; 0 otherwise.
  - `dmem_badmem_e` is 1 only in DATA with the error flag set.
- **Store commit.** Happens at the DATA-cycle edge if there is no error. Byte enables:
  - byte: `1<<addr[1:0]`;
  - half: `4'b0011<<addr[1:0]`;
  - word: `4'b1111`.

  Only enabled lanes of `dmem_wdata_delayed` are written.
- **Faulted access.** Never modifies memory and returns rdata 0.
- **Request changes.** Changes in `dmem_en` or address during WAIT are ignored; the latched request is authoritative.
- **Reset.**
  - State returns to IDLE, the counter clears, and any pending store is discarded.
  - Outputs after reset: `dmem_wait=0`, `dmem_badmem_e=0`, `dmem_rdata=0`.
  - Memory contents are not cleared.
  - A request presented during reset is not accepted.

## Timing
- `WAIT_CYCLES=0`:
  - Latency is 1 cycle: the request at edge N has data/commit in cycle N..N+1.
  - `dmem_wait` never asserts.
  - Throughput is 1 access per cycle.
- `WAIT_CYCLES=k`: `dmem_wait` is high for exactly k cycles after acceptance, then low for the DATA cycle. Throughput is 1 access per k+1 cycles.
- **Read-after-write.** A load accepted in a store's DATA cycle reads the updated word, because the commit precedes the next DATA cycle.
- Faults report with the same latency as a normal access.

## Structure
- Size codes come from the shared constants (`MEM_TYPE_*` widths, `XPR_LEN`, `vscale_platform_constants.vh`); no new local literals.
- One sub-module, `vscale_dmem_bytemask`, is natural: inputs `size` and `addr[1:0]`, outputs a 4-bit mask plus a misaligned/illegal flag. It is pure combinational and is shared with future bus bridges.
- The RAM is an inferred array in the top level. The state machine, counter and latch registers (roughly 200 lines of RTL) live in `vscale_dmem_responder`.

## Test plan
- **Word store then load, `WAIT_CYCLES=0`.** Store 0xDEADBEEF at 0x100, then load 0x100 back-to-back → rdata 0xDEADBEEF in the load's DATA cycle; wait stays 0.
- **Byte lane write.** Word 0x200 = 0x11223344; store byte at 0x203 with wdata 0xAAAAAAAA → a load of 0x200 returns 0xAA223344.
- **Misaligned half.** Half store at 0x102 succeeds. Half load at 0x101 → badmem_e=1 in its DATA cycle, rdata 0, memory unchanged.
- **Out of range.** Load at `BASE_ADDR+4*DEPTH_WORDS` → badmem_e=1. The next valid access completes normally.
- **Wait states.** With `WAIT_CYCLES=2`, a load → wait high for 2 cycles, then data; back-to-back requests are spaced 3 cycles apart.
- **Reset mid-access.** With `WAIT_CYCLES=3`, store 0x55 to 0x40 and assert reset in the second wait cycle → outputs reach their reset values the next cycle, and a later load of 0x40 returns the old value.
